// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// serial_add_pkg : shared state encoding and default width for serial_add_ctrl
// Revision: 1.0
// ============================================================================
package serial_add_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fulladd.sv
`default_nettype none
// ============================================================================
// fulladd : single-bit full adder cell
// Revision: 1.0
// ============================================================================
module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// serial_add_ctrl : bit-serial adder, one bit per cycle LSB-first via one fulladd
// Revision: 1.0
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum;
    logic               fa_cout;
    logic               last_bit;
    logic [WIDTH-1:0]   sum_sh_nxt;

    fulladd u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit   = (cnt == LAST_BIT);
    assign sum_sh_nxt = {fa_sum, sum_sh[WIDTH-1:1]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        carry <= cin_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= sum_sh_nxt;
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // Counter parks on the last bit so it cannot wrap for power-of-two widths
                    if (last_bit) begin
                        sum_out  <= sum_sh_nxt;
                        cout_out <= fa_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// tb_serial_add_ctrl : directed and reference-model checks for serial_add_ctrl
// Revision: 1.0
// ============================================================================
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum_out;
    logic       cout_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout_out  (cout_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drives one operation, measures accept-to-out_valid edges, stalls, then takes the result.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input int stall, output logic [7:0] s, output logic co,
                         output int lat, output bit to);
        int n;
        to = 1'b0;
        @(negedge clk);
        a_in = a; b_in = b; cin_in = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) to = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); lat++; #1; end
        if (lat >= 100) to = 1'b1;
        for (int i = 0; i < stall; i++) @(negedge clk);
        @(negedge clk);
        s  = sum_out;
        co = cout_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_in = 8'h00; b_in = 8'h00; cin_in = 1'b0;
        #12;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
        total++;
        if (sum_out !== 8'h00 || cout_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_result: sum=%h cout=%b, required 00 0", sum_out, cout_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; int lat; bit to;
        do_op(8'h0F, 8'h01, 1'b0, 0, s, co, lat, to);
        total++;
        if (to) begin bad++; $display("FAIL basic_timeout: handshake did not complete"); end
        total++;
        if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d edges, required 8", lat); end
        total++;
        if (s !== 8'h10 || co !== 1'b0) begin
            bad++;
            $display("FAIL basic_sum: sum=%h cout=%b, required 10 0", s, co);
        end
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_return: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_ripple();
        logic [7:0] s; logic co; int lat; bit to;
        do_op(8'hFF, 8'h01, 1'b0, 1, s, co, lat, to);
        total++;
        if (to || s !== 8'h00 || co !== 1'b1) begin
            bad++;
            $display("FAIL ripple_ff_01: sum=%h cout=%b to=%b, required 00 1", s, co, to);
        end
        do_op(8'hFF, 8'hFF, 1'b1, 0, s, co, lat, to);
        total++;
        if (to || s !== 8'hFF || co !== 1'b1) begin
            bad++;
            $display("FAIL ripple_ff_ff_c: sum=%h cout=%b to=%b, required ff 1", s, co, to);
        end
        total++;
        if (lat !== 8) begin bad++; $display("FAIL ripple_latency: got %0d, required 8", lat); end
    endtask

    task automatic test_backpressure();
        int n;
        bit rej_err, stab_err;
        @(negedge clk);
        a_in = 8'h35; b_in = 8'h4A; cin_in = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 a_in = 8'h80; b_in = 8'h80; cin_in = 1'b0;
        rej_err = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b1) rej_err = 1'b1;
            n++;
        end
        total++;
        if (n >= 100 || rej_err) begin
            bad++;
            $display("FAIL bp_run: n=%0d rej_err=%b, required n<100 and in_ready=0 busy=1", n, rej_err);
        end
        stab_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || sum_out !== 8'h80 || cout_out !== 1'b0 || in_ready !== 1'b0)
                stab_err = 1'b1;
        end
        total++;
        if (stab_err) begin
            bad++;
            $display("FAIL bp_stable: sum=%h cout=%b out_valid=%b, required 80 0 1 held 5 cycles",
                     sum_out, cout_out, out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || sum_out !== 8'h80) begin
            bad++;
            $display("FAIL bp_idle: in_ready=%b busy=%b sum=%h, required 1 0 80", in_ready, busy, sum_out);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL bp_second_accept: busy=%b, required 1", busy); end
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n >= 100 || sum_out !== 8'h00 || cout_out !== 1'b1) begin
            bad++;
            $display("FAIL bp_second_sum: sum=%h cout=%b n=%0d, required 00 1", sum_out, cout_out, n);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] s; logic co; int lat; bit to;
        do_op(8'h7E, 8'h81, 1'b0, 0, s, co, lat, to);
        total++;
        if (to || s !== 8'hFF || co !== 1'b0) begin
            bad++;
            $display("FAIL rmid_pre: sum=%h cout=%b, required ff 0", s, co);
        end
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rmid_flags: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
                     out_valid, busy, in_ready);
        end
        total++;
        if (sum_out !== 8'h00 || cout_out !== 1'b0) begin
            bad++;
            $display("FAIL rmid_clear: sum=%h cout=%b, required 00 0", sum_out, cout_out);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        do_op(8'hA5, 8'h5A, 1'b1, 2, s, co, lat, to);
        total++;
        if (to || lat !== 8 || s !== 8'h00 || co !== 1'b1) begin
            bad++;
            $display("FAIL rmid_after: sum=%h cout=%b lat=%0d, required 00 1 lat 8", s, co, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, s; logic c, co; int lat; bit to;
        logic [8:0] exp;
        int errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {8'h00, c};
            do_op(a, b, c, $urandom_range(0, 3), s, co, lat, to);
            total++;
            if (to || lat !== 8 || {co, s} !== exp || out_valid !== 1'b0) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL random_%0d: a=%h b=%h c=%b got %b_%h lat=%0d, required %h lat 8",
                             i, a, b, c, co, s, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, and all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; the reset, which is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit; the requester presents an operand set.
REQ-005 SHALL have port in_ready, output, 1 bit; the controller can accept an operand set.
REQ-006 SHALL have port a_in, input, WIDTH bits; operand A.
REQ-007 SHALL have port b_in, input, WIDTH bits; operand B.
REQ-008 SHALL have port cin_in, input, 1 bit; carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit; the result is available.
REQ-010 SHALL have port out_ready, input, 1 bit; the consumer takes the result.
REQ-011 SHALL have port sum_out, output, WIDTH bits; the sum.
REQ-012 SHALL have port cout_out, output, 1 bit; carry-out from bit WIDTH-1.
REQ-013 SHALL have port busy, output, 1 bit; high while in RUN or DONE.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE, all registered.
- in_ready = 1 only in IDLE.
- out_valid = 1 only in DONE.
REQ-015 SHALL accept an operand set on the edge where in_valid and in_ready are both 1, then:
- load A and B into shift registers;
- load the carry register with cin_in;
- clear the bit counter;
- go to RUN.
REQ-016 SHALL, on each RUN edge, process one bit LSB-first through one full-adder instance, with operands A[0], B[0] and the carry register:
- shift the sum bit into the MSB of the sum register (right shift);
- load the carry register with the adder carry-out;
- shift A and B right by one;
- increment the counter.
REQ-017 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1, so exactly WIDTH RUN edges occur.
- out_valid rises after exactly WIDTH edges following the accept edge.
REQ-018 SHALL produce sum_out == (A+B+cin) mod 2^WIDTH and cout_out == bit WIDTH of (A+B+cin).
REQ-019 SHALL hold sum_out and cout_out stable while out_valid=1, for any duration of out_ready=0.
REQ-020 SHALL return to IDLE on the DONE edge where out_ready=1.
- sum_out and cout_out keep the last result until the next completion.
- Minimum issue interval is WIDTH+2 cycles.
REQ-021 SHALL ignore in_valid, a_in, b_in and cin_in outside IDLE; no queuing and no corruption of the operation in flight.
REQ-022 SHALL ignore out_ready outside DONE.
REQ-023 SHALL size the bit counter as clog2(WIDTH) bits and never let it wrap within one operation.

Reset
REQ-024 SHALL, on rst_n=0 and independent of clk:
- force the state to IDLE;
- clear the shift registers, carry register, counter, sum_out and cout_out;
- drive in_ready=1 (at IDLE) and out_valid=0, busy=0.
REQ-025 SHALL discard any operation in flight when reset is asserted in RUN or DONE, with no result delivered.
REQ-026 SHALL accept a new operand set on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL take the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default constant from a shared package, serial_add_pkg.
REQ-028 SHALL instantiate exactly one existing fulladd cell as its only sub-module; all arithmetic goes through it.

Verification
REQ-029 SHALL verify basic addition and latency at WIDTH=8:
- stimulus: A=8'h0F, B=8'h01, cin=0;
- response: sum_out=8'h10, cout_out=0, out_valid rising exactly 8 edges after accept.
REQ-030 SHALL verify full carry ripple:
- stimulus: A=8'hFF, B=8'h01, cin=0 gives sum_out=8'h00, cout_out=1;
- stimulus: A=8'hFF, B=8'hFF, cin=1 gives sum_out=8'hFF, cout_out=1.
REQ-031 SHALL verify backpressure and busy-time input rejection:
- stimulus: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands held during RUN/DONE;
- response: result stable, second set accepted only after return to IDLE, both results correct.
REQ-032 SHALL verify reset mid-operation:
- stimulus: rst_n pulsed low on the 3rd RUN cycle;
- response: immediately out_valid=0, busy=0, sum_out=0; in_ready=1; a following operation gives a correct result.
REQ-033 SHALL verify against a reference model:
- stimulus: 1000 random A, B, cin with random out_ready stalls;
- response: every result matches A+B+cin, with no lost or duplicated results.
